// File: rtl/temporal_encoder_n.sv
// Temporal encoder: converts a vector of lane values into per-lane edge or pulse
// timing inside a free-running gamma cycle, with a one-deep shadow buffer for loads.
module temporal_encoder_n #(
    parameter int unsigned NUM_INPUTS        = 4,
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned PULSE_WIDTH       = 8,
    parameter int unsigned ENCODING          = 0,
    parameter int unsigned VAL_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
    input  logic                                 clk,
    input  logic                                 grst,
    input  logic                                 load_valid,
    input  logic [NUM_INPUTS*VAL_W-1:0]          load_values,
    output logic                                 load_ready,
    output logic [NUM_INPUTS-1:0]                y,
    output logic                                 gamma_start,
    output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] gamma_count
);

    localparam int unsigned CNT_W = $clog2(GAMMA_CYCLE_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [VAL_W-1:0] INF_VAL = '1;

    logic [CNT_W-1:0]            cnt, cnt_n;
    logic [NUM_INPUTS*VAL_W-1:0] shadow, shadow_n;
    logic [NUM_INPUTS*VAL_W-1:0] act, act_n;
    logic                        shadow_full, shadow_full_n;
    logic [NUM_INPUTS-1:0]       y_n;
    logic [VAL_W-1:0]            lane;
    logic                        wrap, accept, finite, started;

    // Next-state: gamma counter, shadow handshake and wrap-edge transfer
    always_comb begin
        wrap          = (cnt == LAST_CNT);
        accept        = load_valid & load_ready;
        cnt_n         = wrap ? '0 : cnt + CNT_W'(1);
        shadow_n      = shadow;
        shadow_full_n = shadow_full;
        act_n         = act;
        if (wrap) begin
            if (shadow_full) begin
                act_n         = shadow;
                shadow_full_n = 1'b0;
            end else begin
                act_n = {NUM_INPUTS{INF_VAL}};
            end
        end
        if (accept) begin
            shadow_n      = load_values;
            shadow_full_n = 1'b1;
        end
    end

    // Lane outputs for the coming cycle, computed from next-state so y is a flop
    always_comb begin
        y_n     = '0;
        lane    = '0;
        finite  = 1'b0;
        started = 1'b0;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            lane    = act_n[i*VAL_W +: VAL_W];
            finite  = 32'(lane) < 32'(GAMMA_CYCLE_WIDTH);
            started = 32'(cnt_n) >= 32'(lane);
            if (ENCODING == 0) begin
                y_n[i] = finite & started;
            end else begin
                y_n[i] = finite & started &
                         ((32'(cnt_n) - 32'(lane)) < 32'(PULSE_WIDTH));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grst) begin
            cnt         <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
            act         <= {NUM_INPUTS{INF_VAL}};
            y           <= '0;
            load_ready  <= 1'b1;
        end else begin
            cnt         <= cnt_n;
            shadow      <= shadow_n;
            shadow_full <= shadow_full_n;
            act         <= act_n;
            y           <= y_n;
            load_ready  <= ~shadow_full_n;
        end
    end

    // Boundary marker is suppressed while reset is held
    assign gamma_start = (cnt == '0) & ~grst;
    assign gamma_count = cnt;

endmodule

// File: tb/tb_temporal_encoder_n.sv
// Scoreboarded bench for temporal_encoder_n: rising and pulse instances share stimulus
// and are compared every cycle against a behavioural cycle model.
module tb_temporal_encoder_n;

    localparam int G   = 16;
    localparam int PW  = 8;
    localparam int INF = 31;

    logic        clk = 1'b0;
    logic        grst;
    logic        load_valid;
    logic [19:0] load_values;
    logic        ready_r, ready_p, gs_r, gs_p;
    logic [3:0]  y_r, y_p, gc_r, gc_p;

    temporal_encoder_n #(.ENCODING(0)) u_rise (
        .clk(clk), .grst(grst), .load_valid(load_valid), .load_values(load_values),
        .load_ready(ready_r), .y(y_r), .gamma_start(gs_r), .gamma_count(gc_r)
    );

    temporal_encoder_n #(.ENCODING(1)) u_pulse (
        .clk(clk), .grst(grst), .load_valid(load_valid), .load_values(load_values),
        .load_ready(ready_p), .y(y_p), .gamma_start(gs_p), .gamma_count(gc_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] yr;
        logic [3:0] yp;
        logic       gs;
        logic [3:0] gc;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int m_cnt;
    bit m_full;
    bit m_ready;
    int m_shadow[4];
    int m_act[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cnt=%0d got=%0h expected=%0h", tag, m_cnt, got, exp);
        end
    endtask

    // Behavioural model of one clock edge, using the inputs currently driven
    task automatic model_edge();
        bit acc;
        if (grst) begin
            m_cnt = 0; m_full = 0; m_ready = 1;
            for (int i = 0; i < 4; i++) m_act[i] = INF;
        end else begin
            acc = load_valid && m_ready;
            if (m_cnt == G - 1) begin
                for (int i = 0; i < 4; i++) m_act[i] = m_full ? m_shadow[i] : INF;
                m_full = 0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
            if (acc) begin
                for (int i = 0; i < 4; i++) m_shadow[i] = int'(load_values[i*5 +: 5]);
                m_full = 1;
            end
            m_ready = !m_full;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.yr[i] = (m_act[i] < G) && (m_cnt >= m_act[i]);
            e.yp[i] = (m_act[i] < G) && (m_cnt >= m_act[i]) && (m_cnt < m_act[i] + PW);
        end
        e.gs  = (m_cnt == 0) && !grst;
        e.gc  = 4'(m_cnt);
        e.rdy = m_ready;
        return e;
    endfunction

    // One clock: push expectation, advance, pop and compare
    task automatic step();
        exp_t e;
        model_edge();
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow cnt=%0d", m_cnt);
        end else begin
            e = sb.pop_front();
            check("y_rise",   32'(y_r),     32'(e.yr));
            check("y_pulse",  32'(y_p),     32'(e.yp));
            check("gstart",   32'(gs_r),    32'(e.gs));
            check("gstart_p", 32'(gs_p),    32'(e.gs));
            check("gcount",   32'(gc_r),    32'(e.gc));
            check("ready_r",  32'(ready_r), 32'(e.rdy));
            check("ready_p",  32'(ready_p), 32'(e.rdy));
        end
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 40 && m_cnt != target; k++) step();
        if (m_cnt != target) check("run_to_timeout", 32'(m_cnt), 32'(target));
    endtask

    task automatic drive(input int v0, input int v1, input int v2, input int v3);
        load_valid  = 1'b1;
        load_values = {5'(v3), 5'(v2), 5'(v1), 5'(v0)};
    endtask

    initial begin
        logic [3:0] hv;
        grst = 1'b1; load_valid = 1'b0; load_values = '0;
        m_cnt = 0;
        step();
        step();
        check("rst_y",     32'(y_r | y_p), 32'd0);
        check("rst_ready", 32'(ready_r),   32'd1);
        check("rst_gc",    32'(gc_r),      32'd0);
        check("rst_gs",    32'(gs_r),      32'd0);
        grst = 1'b0;
        #1;
        check("rel_gs", 32'(gs_r), 32'd1);

        // Rising mode values {3,0,15,16}
        drive(3, 0, 15, 16);
        step();
        load_valid = 1'b0;
        run_to(0);
        for (int c = 0; c < G; c++) begin
            hv = {1'b0, c == 15, 1'b1, c >= 3};
            check("r030_y", 32'(y_r), 32'(hv));
            step();
        end
        check("r030_wrap", 32'(y_r), 32'd0);
        // Idle gamma cycle: no edges, one gamma_start
        for (int c = 0; c < G; c++) begin
            check("idle_y",  32'(y_r | y_p), 32'd0);
            check("idle_gs", 32'(gs_r),      32'(c == 0));
            step();
        end

        // Pulse mode values {2,12,0,31}
        drive(2, 12, 0, 31);
        step();
        load_valid = 1'b0;
        run_to(0);
        for (int c = 0; c < G; c++) begin
            hv = {1'b0, c <= 7, c >= 12, (c >= 2) && (c <= 9)};
            check("r031_y", 32'(y_p), 32'(hv));
            step();
        end

        // Back-pressure: A accepted, B held until the shadow drains
        run_to(4);
        drive(1, 5, 9, 13);
        step();
        drive(7, 7, 2, 14);
        check("r032_busy", 32'(ready_r), 32'd0);
        run_to(0);
        check("r032_rdy0", 32'(ready_r), 32'd1);
        step();
        check("r032_rdy1", 32'(ready_r), 32'd0);
        load_valid = 1'b0;
        run_to(0);

        // Accept exactly at the wrap edge with the shadow empty
        run_to(15);
        drive(4, 1, 0, 8);
        step();
        load_valid = 1'b0;
        for (int c = 0; c < G; c++) begin
            check("r033_blank", 32'(y_r | y_p), 32'd0);
            step();
        end
        check("r033_show", 32'(y_r), 32'b0100);
        run_to(0);

        // Reset mid-gamma with both active and shadow holding vectors
        run_to(2);
        drive(0, 3, 6, 9);
        step();
        load_valid = 1'b0;
        run_to(2);
        drive(1, 2, 3, 4);
        step();
        load_valid = 1'b0;
        run_to(7);
        grst = 1'b1;
        step();
        check("r035_y",     32'(y_r | y_p), 32'd0);
        check("r035_ready", 32'(ready_r),   32'd1);
        check("r035_gc",    32'(gc_r),      32'd0);
        step();
        grst = 1'b0;
        #1;
        check("r035_gs", 32'(gs_r), 32'd1);
        for (int c = 0; c < G; c++) begin
            check("r035_blank", 32'(y_r | y_p), 32'd0);
            check("r035_cnt",   32'(gc_r),      32'(c));
            step();
        end

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            load_valid  = 1'($urandom_range(0, 1));
            load_values = 20'($urandom);
            grst        = ($urandom_range(0, 99) == 0);
            step();
        end
        grst = 1'b0; load_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
